// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared types and helpers for the note highway
package note_pkg;
    localparam int NUM_LANES = 4;

    typedef logic [NUM_LANES-1:0] lane_mask_t;

    typedef enum logic [1:0] {IDLE, REQ, SAMPLE, SHIFT} state_t;

    function automatic logic [2:0] popcount4(input lane_mask_t m);
        popcount4 = {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
    endfunction
endpackage

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - 2-FF key synchronizer with rising-edge detect
module key_edge_sync
    import note_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  lane_mask_t i_keys,
    output lane_mask_t o_press
);
    lane_mask_t r_sync1;
    lane_mask_t r_sync2;
    lane_mask_t r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_keys;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_press = r_sync2 & ~r_prev;
endmodule

// File: rtl/note_highway.sv
// rtl/note_highway.sv - random-note highway with strike-row scoring
module note_highway
    import note_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int SPAWN_GAP = 2,
    parameter int SCORE_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      run,
    input  logic                      clear,
    input  logic                      tick,
    input  logic [3:0]                rnd,
    output logic                      rnd_en,
    input  logic [3:0]                keys,
    output logic [NUM_LANES*ROWS-1:0] lanes,
    output logic                      hit,
    output logic                      miss,
    output logic                      wrong,
    output logic [SCORE_W-1:0]        score,
    output logic [SCORE_W-1:0]        misses
);
    localparam int GAP_W   = (SPAWN_GAP < 1) ? 1 : $clog2(SPAWN_GAP + 1);
    localparam int STRIKE  = NUM_LANES * (ROWS - 1);

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [2:0] b);
        logic [SCORE_W+2:0] s;
        s = {3'b000, a} + {{SCORE_W{1'b0}}, b};
        sat_add = (|s[SCORE_W+2:SCORE_W]) ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

    state_t                      r_state;
    logic [NUM_LANES*ROWS-1:0]   r_lanes;
    logic [GAP_W-1:0]            r_gap_cnt;
    lane_mask_t                  r_new_row;
    logic                        r_rnd_en, r_hit, r_miss, r_wrong;
    logic [SCORE_W-1:0]          r_score, r_misses;

    lane_mask_t w_press, w_strike, w_hit_mask, w_wrong_mask, w_strike_left, w_ins_row;

    key_edge_sync u_key_sync (
        .clk     (clk),
        .rst     (rst),
        .i_keys  (keys),
        .o_press (w_press)
    );

    // Presses act on the pre-shift strike row; whatever survives them is what a shift discards.
    always_comb begin
        w_strike      = r_lanes[STRIKE +: NUM_LANES];
        w_hit_mask    = w_press & w_strike;
        w_wrong_mask  = w_press & ~w_strike;
        w_strike_left = w_strike & ~w_press;
        w_ins_row     = (r_gap_cnt == '0) ? r_new_row : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lanes   <= '0;
            r_gap_cnt <= '0;
            r_new_row <= '0;
            r_rnd_en  <= 1'b0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_wrong   <= 1'b0;
            r_score   <= '0;
            r_misses  <= '0;
        end else if (clear) begin
            r_state   <= IDLE;
            r_lanes   <= '0;
            r_gap_cnt <= '0;
            r_rnd_en  <= 1'b0;
            r_hit     <= 1'b0;
            r_miss    <= 1'b0;
            r_wrong   <= 1'b0;
            r_score   <= '0;
            r_misses  <= '0;
        end else begin
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_wrong <= 1'b0;
            if (run) begin
                r_hit   <= |w_hit_mask;
                r_wrong <= |w_wrong_mask;
                r_score <= sat_add(r_score, popcount4(w_hit_mask));
                r_lanes <= {w_strike_left, r_lanes[STRIKE-1:0]};
                case (r_state)
                    IDLE: begin
                        if (tick) begin
                            r_state  <= REQ;
                            r_rnd_en <= 1'b1;
                        end
                    end
                    REQ: r_state <= SAMPLE;
                    SAMPLE: begin
                        r_new_row <= rnd;
                        r_rnd_en  <= 1'b0;
                        r_state   <= SHIFT;
                    end
                    SHIFT: begin
                        r_lanes  <= {r_lanes[STRIKE-1:0], w_ins_row};
                        r_miss   <= |w_strike_left;
                        r_misses <= sat_add(r_misses, popcount4(w_strike_left));
                        if (w_ins_row != '0)
                            r_gap_cnt <= GAP_W'(SPAWN_GAP);
                        else if (r_gap_cnt != '0)
                            r_gap_cnt <= r_gap_cnt - 1'b1;
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else begin
                r_state  <= IDLE;
                r_rnd_en <= 1'b0;
            end
        end
    end

    assign rnd_en = r_rnd_en;
    assign lanes  = r_lanes;
    assign hit    = r_hit;
    assign miss   = r_miss;
    assign wrong  = r_wrong;
    assign score  = r_score;
    assign misses = r_misses;
endmodule

// File: doc/note_highway.md
# note_highway

Consumer end of the game's random-note path. On each game step it requests a 4-bit value from the LFSR note generator and turns that value into a lane mask. The mask is inserted at the top of a ROWS-deep, 4-lane note highway, and the highway scrolls down by one row. Player key presses are scored against the bottom strike row, producing hit, miss and wrong pulses plus saturating score and miss counters for the display logic.

## Interface
- ROWS, 16: highway depth in rows, ≥2; row 0 is the top row, row ROWS-1 is the strike row.
- SPAWN_GAP, 2: number of forced-empty rows inserted after every non-empty row; 0 disables the gap.
- SCORE_W, 16: width of the score and miss counters.

- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-high reset.
- run  in  1  game enable; when low the highway freezes and keys are ignored.
- clear  in  1  synchronous clear of the highway, gap counter and counters; FSM returns to IDLE.
- tick  in  1  one-cycle game-step pulse.
- rnd  in  4  value from the note generator; valid while rnd_en is high.
- rnd_en  out  1  request/enable to the note generator.
- keys  in  4  raw lane buttons, active-high, asynchronous to clk.
- lanes  out  4*ROWS  highway contents; row r, lane l is bit 4*r+l.
- hit  out  1  one-cycle pulse on a correct press.
- miss  out  1  one-cycle pulse when a note leaves the strike row unhit.
- wrong  out  1  one-cycle pulse on a press in an empty strike lane.
- score  out  SCORE_W  hit count, saturating.
- misses  out  SCORE_W  missed-note count, saturating.

## Operation
- FSM states: IDLE, REQ, SAMPLE, SHIFT.
- IDLE to REQ: on tick=1 while run=1. A tick in any state other than IDLE is dropped.
- REQ: rnd_en=1, then go to SAMPLE.
- SAMPLE: rnd_en=1; rnd is captured into new_row on the clock edge that leaves SAMPLE, then go to SHIFT.
- SHIFT: lanes shifts down one row. The inserted row 0 is new_row if gap_cnt=0, otherwise 4'b0000.
  - If the inserted row is non-zero, gap_cnt loads SPAWN_GAP.
  - If gap_cnt>0, gap_cnt decrements by 1.
  - The next state is IDLE.
- rnd=0 inserts an empty row and does not load the gap counter.
- Miss accounting in SHIFT:
  - The strike row value being discarded (after any same-cycle hit clears) is popcounted.
  - misses increases by that popcount, saturating at 2^SCORE_W-1.
  - miss pulses if the popcount is greater than 0.
- Keys pass through a 2-FF synchronizer and rising-edge detector, giving press[3:0]. Each press is evaluated when run=1, in any FSM state.
- For each lane with press=1:
  - If the strike-row bit is 1, the bit is cleared and the lane counts as a hit.
  - If the strike-row bit is 0, the lane counts as wrong.
- A hit pulse covers all hits in a cycle; score increases by the number of hit lanes, saturating.
- Simultaneous press and SHIFT: the press is evaluated first, against the pre-shift strike row. A bit cleared by the press is neither shifted out as a miss nor counted twice.
- run=0: FSM holds IDLE; lanes, counters and gap_cnt hold; rnd_en=0; press is discarded.
- clear has priority over all other updates, except that rst dominates clear.
- rnd_en is high only in REQ and SAMPLE.

## Timing
- Reset values:
  - lanes = 0, score = 0, misses = 0.
  - hit = wrong = miss = 0, rnd_en = 0.
  - FSM in IDLE, gap_cnt = 0, new_row = 0.
  - Synchronizer flops are 0.
- Latency from tick: rnd_en rises at cycle t+1 and stays high for t+1..t+2. rnd is sampled at the end of t+2. lanes updates at the end of t+3, and the FSM is back in IDLE at t+4.
- The minimum tick spacing that drops no ticks is 4 cycles.
- Key latency: a raw key edge gives press 2–3 cycles later. hit/wrong are registered and appear in the cycle after press; score updates in that same cycle.
- miss and misses update at the edge that completes SHIFT.
- rst asserted mid-operation clears everything immediately. A pending request is abandoned, and rnd_en falls without waiting for a clock.

## Structure
- Package note_pkg:
  - NUM_LANES = 4.
  - FSM state enum (IDLE, REQ, SAMPLE, SHIFT).
  - lane_mask_t, a 4-bit type.
  - popcount4 function.
- Sub-module key_edge_sync: 4-bit 2-FF synchronizer plus rising-edge detector, with asynchronous rst. Instantiated once.
- The top level holds the FSM, the highway shift register, the gap counter and the saturating counters.

## Test plan
- Reset, then tick with rnd=4'b1010 → rnd_en high for 2 cycles; lanes[3:0]=4'b1010 at t+4; gap_cnt=2. The next two ticks insert 0 even with rnd=4'b1111.
- ROWS=4, SPAWN_GAP=0; tick 4 times with rnd=4'b0001 → strike row = 0001. Press key0 → hit pulse, score=1, strike row bit cleared. The next SHIFT leaves misses=0.
- Same setup with no press, rnd=4'b0111 shifted out → miss pulse, misses += 3.
- Press key2 while strike row = 0001 → wrong pulse, score unchanged. Press key0 in the same cycle as SHIFT → hit counted; misses unchanged.
- Assert tick at t and t+2 → the second tick is dropped, with exactly one row inserted. Set run=0, then tick → no rnd_en and lanes unchanged. Preload score=2^SCORE_W-1 and hit → score stays saturated.
- Assert rst during SAMPLE → rnd_en low immediately, lanes=0 and counters 0. Assert clear during SHIFT → lanes=0 and FSM in IDLE next cycle.
